// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 constants and the job scheduler state encoding.
package aes_pkg;
    localparam int AES_W            = 128;
    localparam int AES_ROUNDS       = 10;
    localparam int AES_CORE_LATENCY = AES_ROUNDS + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr.
module rr_arbiter #(
    parameter int N = 2,
    localparam int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt_onehot,
    output logic [IDW-1:0] gnt_idx,
    output logic           any
);
    logic [N-1:0] hi;
    logic [N-1:0] sel;

    // Requests at or above ptr take priority; otherwise wrap to the lowest one.
    always_comb begin
        hi      = req & ({N{1'b1}} << ptr);
        sel     = |hi ? hi : req;
        gnt_idx = '0;
        for (int k = N - 1; k >= 0; k--)
            if (sel[k]) gnt_idx = IDW'(k);
    end

    assign any        = |req;
    assign gnt_onehot = any ? N'(1) << gnt_idx : '0;
endmodule

// File: rtl/aes_job_sched.sv
// aes_job_sched: round-robin scheduler sharing one iterative AES-128 core among requesters.
module aes_job_sched
    import aes_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int LATENCY = AES_CORE_LATENCY,
    parameter int W       = AES_W,
    localparam int IDW    = $clog2(NREQ),
    localparam int CW     = $clog2(LATENCY + 1)
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] req_ready,
    input  logic [NREQ*W-1:0] req_plain,
    input  logic [NREQ*W-1:0] req_key,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [IDW-1:0]  resp_id,
    output logic [W-1:0]    resp_cipher,
    output logic            core_load,
    output logic [W-1:0]    core_plain,
    output logic [W-1:0]    core_key,
    input  logic [W-1:0]    core_cipher,
    output logic            busy
);
    state_t         state, state_nx;
    logic [IDW-1:0] rr_ptr, gnt_idx, id_q;
    logic [NREQ-1:0] gnt_oh;
    logic           any;
    logic [CW-1:0]  cnt;
    logic           last;
    logic [W-1:0]   plain_q, key_q, cipher_q;

    rr_arbiter #(.N(NREQ)) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .gnt_onehot(gnt_oh),
        .gnt_idx   (gnt_idx),
        .any       (any)
    );

    assign last = cnt == CW'(LATENCY - 1);

    always_comb begin
        state_nx   = state;
        req_ready  = '0;
        core_load  = 1'b0;
        resp_valid = 1'b0;
        busy       = state != S_IDLE;
        case (state)
            S_IDLE: begin
                req_ready = gnt_oh;
                state_nx  = any ? S_LOAD : S_IDLE;
            end
            S_LOAD: begin
                core_load = 1'b1;
                state_nx  = S_RUN;
            end
            S_RUN:  state_nx = last ? S_DONE : S_RUN;
            S_DONE: begin
                resp_valid = 1'b1;
                state_nx   = resp_ready ? S_IDLE : S_DONE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            rr_ptr   <= '0;
            cnt      <= '0;
            id_q     <= '0;
            plain_q  <= '0;
            key_q    <= '0;
            cipher_q <= '0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && any) begin
                id_q    <= gnt_idx;
                plain_q <= req_plain[W*gnt_idx +: W];
                key_q   <= req_key[W*gnt_idx +: W];
                rr_ptr  <= gnt_idx == IDW'(NREQ - 1) ? '0 : gnt_idx + 1'b1;
            end
            cnt <= state == S_LOAD ? '0 : state == S_RUN ? cnt + 1'b1 : cnt;
            if (state == S_RUN && last) cipher_q <= core_cipher;
        end
    end

    assign resp_id     = id_q;
    assign resp_cipher = cipher_q;
    assign core_plain  = plain_q;
    assign core_key    = key_q;
endmodule

// File: tb/tb_aes_job_sched.sv
// tb_aes_job_sched: directed and random checks of the AES job scheduler against a
// behavioural AES-128 core and a cycle-age scheduling model.
module tb_aes_job_sched;
    localparam int NREQ = 2;
    localparam int LAT  = 11;
    localparam int W    = 128;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CZ = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_plain = '0;
    logic [NREQ*W-1:0] req_key = '0;
    logic              resp_valid;
    logic              resp_ready = 1'b0;
    logic [0:0]        resp_id;
    logic [W-1:0]      resp_cipher, core_plain, core_key, core_cipher;
    logic              core_load, busy;

    int checks = 0, errors = 0, cyc = 0;

    always #5 clock = ~clock;

    aes_job_sched #(.NREQ(NREQ), .LATENCY(LAT), .W(W)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_plain(req_plain), .req_key(req_key),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_cipher(resp_cipher),
        .core_load(core_load), .core_plain(core_plain), .core_key(core_key),
        .core_cipher(core_cipher), .busy(busy)
    );

    function automatic logic [7:0] xt(logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(logic [7:0] a, logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = xt(a);
        end
        return p;
    endfunction

    // S-box from the field inverse x^254 followed by the affine map.
    function automatic logic [7:0] sb(logic [7:0] x);
        logic [7:0] r = 8'h01, s = x;
        for (int i = 0; i < 7; i++) begin
            s = gm(s, s);
            r = gm(r, s);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_enc(logic [127:0] pt, logic [127:0] key);
        logic [7:0] s[16], k[16], t[16];
        logic [7:0] rc = 8'h01, a0, a1, a2, a3, k0, k1, k2, k3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) begin
            k[i] = key[127-8*i -: 8];
            s[i] = pt[127-8*i -: 8] ^ k[i];
        end
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sb(s[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)]);
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (rnd < 10) begin
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            k0 = sb(k[13]) ^ rc; k1 = sb(k[14]); k2 = sb(k[15]); k3 = sb(k[12]);
            k[0] ^= k0; k[1] ^= k1; k[2] ^= k2; k[3] ^= k3;
            for (int i = 4; i < 16; i++) k[i] ^= k[i-4];
            rc = xt(rc);
            for (int i = 0; i < 16; i++) s[i] ^= k[i];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    // Round core stand-in: result valid only on the LAT-th cycle after the load edge.
    logic [W-1:0] core_res = '0;
    int core_ctr = 0;
    always @(posedge clock) begin
        if (core_load) begin
            core_res <= aes_enc(core_plain, core_key);
            core_ctr <= LAT;
        end else if (core_ctr > 0) core_ctr <= core_ctr - 1;
    end
    assign core_cipher = core_ctr == 1 ? core_res : ~core_res;

    bit m_act = 0;
    int m_age = 0, m_rr = 0, m_id = 0;
    logic [W-1:0] m_plain, m_key, m_exp;
    logic [NREQ-1:0] acc_q = '0;
    logic prev_rv = 1'b0;
    int gnt_q[$], gcyc_q[$], rise_q[$], hcyc_q[$], rid_q[$];
    logic [W-1:0] rc_q[$];

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_logs();
        gnt_q.delete(); gcyc_q.delete(); rise_q.delete();
        hcyc_q.delete(); rid_q.delete(); rc_q.delete();
    endtask

    task automatic model_step();
        logic [NREQ-1:0] e_rdy = '0;
        int g = -1;
        bit e_rv;
        if (!reset_n) begin
            m_act = 0; m_rr = 0; prev_rv = 1'b0; acc_q = '0;
            chk("rst_req_ready", req_ready, 0);
            chk("rst_resp_valid", resp_valid, 0);
            chk("rst_core_load", core_load, 0);
            chk("rst_busy", busy, 0);
            chk("rst_resp_id", resp_id, 0);
            chk("rst_resp_cipher", resp_cipher, 0);
            return;
        end
        if (!m_act)
            for (int k = NREQ - 1; k >= 0; k--)
                if (req_valid[(m_rr + k) % NREQ]) g = (m_rr + k) % NREQ;
        if (g >= 0) e_rdy[g] = 1'b1;
        e_rv = m_act && m_age >= LAT + 1;
        chk("onehot0_req_ready", $onehot0(req_ready), 1);
        chk("req_ready", req_ready, e_rdy);
        chk("busy", busy, m_act);
        chk("core_load", core_load, m_act && m_age == 0);
        chk("resp_valid", resp_valid, e_rv);
        if (m_act) begin
            chk("core_plain", core_plain, m_plain);
            chk("core_key", core_key, m_key);
        end
        if (e_rv) begin
            chk("resp_id", resp_id, m_id);
            chk("resp_cipher", resp_cipher, m_exp);
        end
        for (int k = 0; k < NREQ; k++)
            if (req_ready[k]) begin gnt_q.push_back(k); gcyc_q.push_back(cyc); end
        if (resp_valid && !prev_rv) rise_q.push_back(cyc);
        prev_rv = resp_valid;
        if (resp_valid && resp_ready) begin
            hcyc_q.push_back(cyc); rid_q.push_back(int'(resp_id)); rc_q.push_back(resp_cipher);
        end
        acc_q = req_valid & req_ready;
        if (g >= 0) begin
            m_act = 1; m_age = 0; m_id = g;
            m_plain = req_plain[g*W +: W];
            m_key   = req_key[g*W +: W];
            m_exp   = aes_enc(m_plain, m_key);
            m_rr    = (g + 1) % NREQ;
        end else if (m_act) begin
            if (e_rv && resp_ready) m_act = 0;
            else m_age++;
        end
    endtask

    task automatic tick();
        @(negedge clock);
        cyc++;
        model_step();
        @(posedge clock);
        #1;
        req_valid &= ~acc_q;
    endtask

    task automatic set_job(int i, logic [127:0] p, logic [127:0] k);
        req_plain[i*W +: W] = p;
        req_key[i*W +: W]   = k;
    endtask

    task automatic drain(int lim);
        int n = 0;
        while ((req_valid != 0 || busy) && n < lim) begin tick(); n++; end
        chk("drain_timeout", req_valid != 0 || busy, 0);
    endtask

    initial begin
        chk("model_fips_c1", aes_enc(P1, K1), C1);
        chk("model_zero", aes_enc('0, '0), CZ);

        repeat (3) tick();
        reset_n = 1'b1;
        repeat (2) tick();

        // Single job from requester 0.
        clear_logs();
        set_job(0, P1, K1);
        resp_ready = 1'b1;
        req_valid = 2'b01;
        drain(100);
        chk("t1_gnt", gnt_q.size() > 0 ? gnt_q[0] : -1, 0);
        chk("t1_latency", rise_q.size() > 0 && gcyc_q.size() > 0 ? rise_q[0] - gcyc_q[0] : -1, LAT + 2);
        chk("t1_id", rid_q.size() > 0 ? rid_q[0] : -1, 0);
        chk("t1_cipher", rc_q.size() > 0 ? rc_q[0] : '0, C1);

        // Requester 1 alone moves the pointer back to 0.
        clear_logs();
        set_job(1, '0, '0);
        req_valid = 2'b10;
        drain(100);
        chk("t1b_id", rid_q.size() > 0 ? rid_q[0] : -1, 1);
        chk("t1b_cipher", rc_q.size() > 0 ? rc_q[0] : '0, CZ);

        // Contention: both valid together, repeated.
        clear_logs();
        for (int r = 0; r < 4; r++) begin
            req_valid = 2'b11;
            drain(200);
        end
        chk("t2_count", gnt_q.size(), 8);
        for (int i = 0; i < 8 && i < gnt_q.size(); i++) chk("t2_order", gnt_q[i], i % 2);

        // Backpressure in DONE.
        clear_logs();
        resp_ready = 1'b0;
        req_valid = 2'b11;
        for (int n = 0; n < 40 && !resp_valid; n++) tick();
        chk("t3_reach_done", resp_valid, 1);
        for (int n = 0; n < 20; n++) begin
            tick();
            chk("t3_hold_valid", resp_valid, 1);
            chk("t3_hold_id", resp_id, 0);
            chk("t3_hold_cipher", resp_cipher, C1);
            chk("t3_hold_ready", req_ready, 0);
        end
        resp_ready = 1'b1;
        drain(100);
        chk("t3_second_gnt", gnt_q.size() > 1 ? gnt_q[1] : -1, 1);
        chk("t3_gnt_after_release", gcyc_q.size() > 1 && hcyc_q.size() > 0 ? gcyc_q[1] - hcyc_q[0] : -1, 1);

        // Back-to-back FIPS and all-zero vectors.
        clear_logs();
        set_job(0, P1, K1);
        set_job(1, '0, '0);
        req_valid = 2'b11;
        drain(100);
        chk("t4_id0", rid_q.size() > 1 ? rid_q[0] : -1, 0);
        chk("t4_id1", rid_q.size() > 1 ? rid_q[1] : -1, 1);
        chk("t4_c0", rc_q.size() > 1 ? rc_q[0] : '0, C1);
        chk("t4_c1", rc_q.size() > 1 ? rc_q[1] : '0, CZ);
        chk("t4_spacing", gcyc_q.size() > 1 ? gcyc_q[1] - gcyc_q[0] : -1, LAT + 3);

        // Reset in the middle of RUN (cnt = 5).
        clear_logs();
        req_valid = 2'b01;
        for (int n = 0; n < 10 && gcyc_q.size() == 0; n++) tick();
        repeat (6) tick();
        reset_n = 1'b0;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_resp_valid", resp_valid, 0);
        chk("t5_core_load", core_load, 0);
        chk("t5_req_ready", req_ready, 0);
        chk("t5_resp_id", resp_id, 0);
        chk("t5_resp_cipher", resp_cipher, 0);
        chk("t5_core_plain", core_plain, 0);
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (20) tick();
        chk("t5_no_resp", rise_q.size(), 0);
        clear_logs();
        req_valid = 2'b01;
        drain(100);
        chk("t5_after_id", rid_q.size() > 0 ? rid_q[0] : -1, 0);
        chk("t5_after_cipher", rc_q.size() > 0 ? rc_q[0] : '0, C1);

        // Random traffic with random backpressure.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++)
                if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    set_job(i, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
                    req_valid[i] = 1'b1;
                end
            resp_ready = 1'($urandom_range(0, 1));
            tick();
        end
        resp_ready = 1'b1;
        drain(200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
